// File: rtl/alu_seq_pkg.sv
// Package for the ALU operation sequencer.
// Holds the ALU function codes, instruction class and condition codes,
// flag bit indices, instruction field positions and the FSM state type.
package alu_seq_pkg;

  // ALU function codes driven on FunSel[3:0]
  localparam logic [3:0] FN_PASS_A = 4'h0;
  localparam logic [3:0] FN_PASS_B = 4'h1;
  localparam logic [3:0] FN_NOT_A  = 4'h2;
  localparam logic [3:0] FN_NOT_B  = 4'h3;
  localparam logic [3:0] FN_ADD    = 4'h4;
  localparam logic [3:0] FN_ADC    = 4'h5;
  localparam logic [3:0] FN_SUB    = 4'h6;
  localparam logic [3:0] FN_AND    = 4'h7;
  localparam logic [3:0] FN_OR     = 4'h8;
  localparam logic [3:0] FN_XOR    = 4'h9;
  localparam logic [3:0] FN_NAND   = 4'hA;
  localparam logic [3:0] FN_LSL    = 4'hB;
  localparam logic [3:0] FN_LSR    = 4'hC;
  localparam logic [3:0] FN_ASR    = 4'hD;
  localparam logic [3:0] FN_CSL    = 4'hE;
  localparam logic [3:0] FN_CSR    = 4'hF;

  // Instruction classes
  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_COND = 2'b01;
  localparam logic [1:0] CLS_CMP  = 2'b10;
  localparam logic [1:0] CLS_ILL  = 2'b11;

  // Condition codes for class 01
  localparam logic [1:0] COND_EQ = 2'b00;
  localparam logic [1:0] COND_NE = 2'b01;
  localparam logic [1:0] COND_CS = 2'b10;
  localparam logic [1:0] COND_MI = 2'b11;

  // Flag bit indices within FlagsIn / FlagsSnap
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_O = 3;

  // Instruction field bit positions
  localparam int CLS_HI  = 15;
  localparam int CLS_LO  = 14;
  localparam int FN_HI   = 13;
  localparam int FN_LO   = 10;
  localparam int W_BIT   = 9;
  localparam int S_BIT   = 8;
  localparam int RD_HI   = 7;
  localparam int RD_LO   = 6;
  localparam int RA_HI   = 5;
  localparam int RA_LO   = 4;
  localparam int RB_HI   = 3;
  localparam int RB_LO   = 2;
  localparam int COND_HI = 1;
  localparam int COND_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational instruction decoder.
// Ports:
//   ir        in  16  registered instruction word
//   zcn       in  3   ALU flags {N,C,Z} used for predication
//   funsel    out 5   {W, fn} for the ALU
//   wf        out 1   flag write enable (forced for compares)
//   regwe     out 1   register-file write enable (ALU classes only)
//   sel_a/b/d out 2   register-file selects Ra/Rb/Rd
//   cond_true out 1   condition field evaluates true on zcn
//   illegal   out 1   class 2'b11
//   skip      out 1   conditional instruction with false predicate
module alu_instr_decode
  import alu_seq_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [2:0]  zcn,
  output logic [4:0]  funsel,
  output logic        wf,
  output logic        regwe,
  output logic [1:0]  sel_a,
  output logic [1:0]  sel_b,
  output logic [1:0]  sel_d,
  output logic        cond_true,
  output logic        illegal,
  output logic        skip
);

  logic [1:0] cls;

  assign cls    = ir[CLS_HI:CLS_LO];
  assign funsel = {ir[W_BIT], ir[FN_HI:FN_LO]};
  assign sel_a  = ir[RA_HI:RA_LO];
  assign sel_b  = ir[RB_HI:RB_LO];
  assign sel_d  = ir[RD_HI:RD_LO];

  // Compares exist only to set flags, so their S bit is overridden.
  assign wf    = (cls == CLS_CMP) ? 1'b1 : ir[S_BIT];
  assign regwe = (cls == CLS_ALU) || (cls == CLS_COND);

  always_comb begin
    cond_true = 1'b0;
    unique case (ir[COND_HI:COND_LO])
      COND_EQ: cond_true = zcn[FLAG_Z];
      COND_NE: cond_true = !zcn[FLAG_Z];
      COND_CS: cond_true = zcn[FLAG_C];
      COND_MI: cond_true = zcn[FLAG_N];
      default: cond_true = 1'b0;
    endcase
  end

  assign illegal = (cls == CLS_ILL);
  assign skip    = (cls == CLS_COND) && !cond_true;

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts instruction words, decodes them, issues
// one ALU/register-file operation per instruction and retires it.
// Ports:
//   Clock, Reset      clock (rising edge), async active-high reset
//   InstrValid/Ready  instruction handshake; InstrIn is the word
//   FlagsIn           ALU FlagsOut [0]Z [1]C [2]N [3]O
//   FunSel, WF        ALU function select and flag write enable
//   RegSelA/B/D, RegWE register-file selects and write enable
//   Done/Skipped/Illegal  retirement pulses
//   FlagsSnap         FlagsIn sampled in DONE, held until the next DONE
//   InstrCount        retired instruction count (wraps)
//   StateDbg          current FSM state
//
// Handshake: a word transfers on a rising edge where InstrValid and
// InstrReady are both high. InstrReady is high only in IDLE and does not
// depend on InstrValid; the source must hold InstrIn stable while InstrValid
// is high until the transfer. Valid seen in any other state is simply left
// pending.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 InstrValid,
  input  logic [15:0]          InstrIn,
  output logic                 InstrReady,
  input  logic [3:0]           FlagsIn,
  output logic [4:0]           FunSel,
  output logic                 WF,
  output logic [1:0]           RegSelA,
  output logic [1:0]           RegSelB,
  output logic [1:0]           RegSelD,
  output logic                 RegWE,
  output logic                 Done,
  output logic                 Skipped,
  output logic                 Illegal,
  output logic [3:0]           FlagsSnap,
  output logic [CNT_WIDTH-1:0] InstrCount,
  output logic [1:0]           StateDbg
);

  seq_state_e  state_q, state_d;
  logic [15:0] ir_q;
  logic        skip_q;

  logic [4:0]  dec_funsel;
  logic        dec_wf, dec_regwe, dec_cond_true, dec_illegal, dec_skip;
  logic [1:0]  dec_sel_a, dec_sel_b, dec_sel_d;

  alu_instr_decode u_decode (
    .ir        (ir_q),
    .zcn       (FlagsIn[FLAG_N:FLAG_Z]),
    .funsel    (dec_funsel),
    .wf        (dec_wf),
    .regwe     (dec_regwe),
    .sel_a     (dec_sel_a),
    .sel_b     (dec_sel_b),
    .sel_d     (dec_sel_d),
    .cond_true (dec_cond_true),
    .illegal   (dec_illegal),
    .skip      (dec_skip)
  );

  assign StateDbg = state_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      ir_q       <= '0;
      skip_q     <= 1'b0;
      FlagsSnap  <= '0;
      InstrCount <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && InstrValid) ir_q <= InstrIn;
      // The predicate is resolved once, in DECODE, against the flags left
      // by the previous instruction; keep that verdict for the DONE pulse.
      if (state_q == ST_DECODE) skip_q <= dec_skip;
      if (state_q == ST_DONE) begin
        FlagsSnap  <= FlagsIn;
        InstrCount <= InstrCount + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    InstrReady = 1'b0;
    FunSel     = '0;
    WF         = 1'b0;
    RegWE      = 1'b0;
    RegSelA    = '0;
    RegSelB    = '0;
    RegSelD    = '0;
    Done       = 1'b0;
    Skipped    = 1'b0;
    Illegal    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        InstrReady = 1'b1;
        if (InstrValid) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = (dec_illegal || dec_skip) ? ST_DONE : ST_EXEC;
      end
      ST_EXEC: begin
        FunSel  = dec_funsel;
        WF      = dec_wf;
        RegWE   = dec_regwe;
        RegSelA = dec_sel_a;
        RegSelB = dec_sel_b;
        RegSelD = dec_sel_d;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        Done    = 1'b1;
        Skipped = skip_q;
        Illegal = dec_illegal;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
